seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_if.sv | 22 ++
 rtl/seq_divider.sv | 128 ++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The requester drives operands and start; the divider returns status and results.
interface seq_divider_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       dz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dz
  );
endinterface

// File: rtl/seq_divider.sv
// 8-bit by 4-bit restoring divider, one quotient bit per cycle.
// Divide-by-zero short-circuits straight to DONE with saturated quotient.
module seq_divider (
  input  logic              clk,
  input  logic              rst,
  seq_divider_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic [7:0] dvd;
  logic [3:0] dvs;
  logic [4:0] prem;
  logic [7:0] quo;
  logic [3:0] rem;
  logic       dz_q;

  logic [4:0] shifted;
  logic [5:0] trial;
  logic       no_borrow;
  logic [4:0] prem_nxt;
  logic [7:0] dvd_nxt;

  function automatic logic [5:0] cla_add5(
    input logic [4:0] a,
    input logic [4:0] b,
    input logic       cin
  );
    logic [4:0] g;
    logic [4:0] p;
    logic [5:0] c;
    g = a & b;
    p = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0])
         | (&p[2:0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1])
         | (&p[3:1] & g[0]) | (&p[3:0] & cin);
    c[5] = g[4] | (p[4] & g[3]) | (&p[4:3] & g[2])
         | (&p[4:2] & g[1]) | (&p[4:1] & g[0])
         | (&p[4:0] & cin);
    return {c[5], p ^ c[4:0]};
  endfunction

  // Carry out of a + ~b + 1 is the "no borrow" indication.
  always_comb begin
    shifted   = {prem[3:0], dvd[7]};
    trial     = cla_add5(shifted, ~{1'b0, dvs}, 1'b1);
    no_borrow = trial[5];
    prem_nxt  = no_borrow ? trial[4:0] : shifted;
    dvd_nxt   = {dvd[6:0], no_borrow};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start)
          state_nxt = (bus.divisor == 4'd0) ? DONE : CALC;
      end
      CALC: begin
        if (cnt == 3'd7) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 3'd0;
      dvd  <= 8'd0;
      dvs  <= 4'd0;
      prem <= 5'd0;
      quo  <= 8'd0;
      rem  <= 4'd0;
      dz_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            dvd  <= bus.dividend;
            dvs  <= bus.divisor;
            prem <= 5'd0;
            cnt  <= 3'd0;
            if (bus.divisor == 4'd0) begin
              quo  <= 8'hFF;
              rem  <= bus.dividend[3:0];
              dz_q <= 1'b1;
            end
          end
        end
        CALC: begin
          dvd  <= dvd_nxt;
          prem <= prem_nxt;
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            quo  <= dvd_nxt;
            rem  <= prem_nxt[3:0];
            dz_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == CALC) || (state == DONE);
  assign bus.done      = (state == DONE);
  assign bus.quotient  = quo;
  assign bus.remainder = rem;
  assign bus.dz        = dz_q;

endmodule
